// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter.
//   state_e    : arbiter FSM states (IDLE, GNT_I, GNT_D)
//   gnt_id_e   : grant identifiers for the round-robin record (I-cache / D-cache)
//   *_DEF      : default block-address and block-data widths
package mem_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    typedef enum logic {
        ID_I = 1'b0,
        ID_D = 1'b1
    } gnt_id_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: I-cache (read only) and D-cache (read / write-back)
// share one memory port. Arbitration happens only in IDLE; ties go round-robin.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   ic_read, ic_addr           : I-cache request (held until ic_ready)
//   ic_ready, ic_rdata         : I-cache completion / read data
//   dc_read, dc_write, dc_addr,
//   dc_wdata                   : D-cache request (held until dc_ready)
//   dc_ready, dc_rdata         : D-cache completion / read data
//   mem_read, mem_write,
//   mem_addr, mem_wdata        : memory command (registered)
//   mem_rdata, mem_ready       : memory response
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ready,
    output logic [DATA_W-1:0] ic_rdata,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_e            state;
    gnt_id_e           last_gnt;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic dc_req;
    logic pick_d;

    // D wins when alone, or on a tie when I was served last.
    always_comb begin
        dc_req = dc_read | dc_write;
        pick_d = dc_req && (!ic_read || (last_gnt == ID_I));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_gnt  <= ID_I;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state     <= GNT_D;
                        last_gnt  <= ID_D;
                        cmd_addr  <= dc_addr;
                        cmd_wdata <= dc_wdata;
                        // write outranks read if both are raised
                        mem_write <= dc_write;
                        mem_read  <= ~dc_write;
                    end else if (ic_read) begin
                        state     <= GNT_I;
                        last_gnt  <= ID_I;
                        cmd_addr  <= ic_addr;
                        cmd_wdata <= '0;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                    end
                end
                GNT_I, GNT_D: begin
                    // Hold the command regardless of the requester until memory answers.
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

    // Completion is forwarded combinationally to the granted cache only;
    // mem_ready seen in IDLE falls through both terms.
    assign ic_ready = (state == GNT_I) && mem_ready;
    assign dc_ready = (state == GNT_D) && mem_ready;
    assign ic_rdata = mem_rdata;
    assign dc_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk;
    logic          rst_n;
    logic          ic_read;
    logic [AW-1:0] ic_addr;
    logic          ic_ready;
    logic [DW-1:0] ic_rdata;
    logic          dc_read;
    logic          dc_write;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_wdata;
    logic          dc_ready;
    logic [DW-1:0] dc_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ic_read  (ic_read),
        .ic_addr  (ic_addr),
        .ic_ready (ic_ready),
        .ic_rdata (ic_rdata),
        .dc_read  (dc_read),
        .dc_write (dc_write),
        .dc_addr  (dc_addr),
        .dc_wdata (dc_wdata),
        .dc_ready (dc_ready),
        .dc_rdata (dc_rdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One vector = inputs for one cycle plus the outputs expected in that same
    // cycle (registered outputs reflect earlier edges, readies are combinational).
    typedef struct {
        bit            rst;
        bit            icr;
        logic [AW-1:0] ica;
        bit            dcr;
        bit            dcw;
        logic [AW-1:0] dca;
        logic [DW-1:0] dcwd;
        bit            mrdy;
        logic [DW-1:0] mrd;
        bit            e_mr;
        bit            e_mw;
        logic [AW-1:0] e_ma;
        bit            chk_wd;
        logic [DW-1:0] e_mwd;
        bit            e_ir;
        bit            e_dr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit rst, bit icr, logic [AW-1:0] ica, bit dcr, bit dcw,
                               logic [AW-1:0] dca, logic [DW-1:0] dcwd, bit mrdy,
                               logic [DW-1:0] mrd, bit e_mr, bit e_mw, logic [AW-1:0] e_ma,
                               bit chk_wd, logic [DW-1:0] e_mwd, bit e_ir, bit e_dr);
        vec_t r;
        r.rst = rst; r.icr = icr; r.ica = ica; r.dcr = dcr; r.dcw = dcw;
        r.dca = dca; r.dcwd = dcwd; r.mrdy = mrdy; r.mrd = mrd;
        r.e_mr = e_mr; r.e_mw = e_mw; r.e_ma = e_ma; r.chk_wd = chk_wd;
        r.e_mwd = e_mwd; r.e_ir = e_ir; r.e_dr = e_dr;
        return r;
    endfunction

    task automatic clear_inputs();
        ic_read = 0; ic_addr = '0; dc_read = 0; dc_write = 0;
        dc_addr = '0; dc_wdata = '0; mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [DW-1:0] BEEF = 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF;
    localparam logic [DW-1:0] RD2  = 128'h5A5A_0000_1111_2222;

    initial begin
        string tag;
        int    got [6];
        int    n;
        rst_n = 1'b1;
        clear_inputs();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_ic_ready", ic_ready, 0);
        chk("rst_dc_ready", dc_ready, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single I-cache read, memory answers 3 cycles after the command.
        vecs.push_back(v(1,1,28'h10,0,0,0,0,0,BEEF, 0,0,0,    0,0, 0,0));
        vecs.push_back(v(0,1,28'h10,0,0,0,0,0,BEEF, 1,0,28'h10,1,0, 0,0));
        vecs.push_back(v(0,1,28'h10,0,0,0,0,0,BEEF, 1,0,28'h10,0,0, 0,0));
        vecs.push_back(v(0,1,28'h10,0,0,0,0,0,BEEF, 1,0,28'h10,0,0, 0,0));
        vecs.push_back(v(0,1,28'h10,0,0,0,0,1,BEEF, 1,0,28'h10,0,0, 1,0));
        vecs.push_back(v(0,0,0,     0,0,0,0,0,BEEF, 0,0,0,    0,0, 0,0));
        // Tie right after reset: D first, one IDLE cycle, then I; mem_ready in IDLE ignored.
        vecs.push_back(v(1,1,28'h100,1,0,28'h200,0,0,RD2, 0,0,0,      0,0, 0,0));
        vecs.push_back(v(0,1,28'h100,1,0,28'h200,0,1,RD2, 1,0,28'h200,0,0, 0,1));
        vecs.push_back(v(0,1,28'h100,0,0,28'h200,0,0,RD2, 0,0,0,      0,0, 0,0));
        vecs.push_back(v(0,1,28'h100,0,0,28'h200,0,1,RD2, 1,0,28'h100,0,0, 1,0));
        vecs.push_back(v(0,0,0,      0,0,0,      0,1,RD2, 0,0,0,      0,0, 0,0));
        // Write-back (read+write both high -> write) then refill, I served between.
        vecs.push_back(v(1,1,28'h400,1,1,28'h300,128'h55,0,RD2, 0,0,0,      0,0,      0,0));
        vecs.push_back(v(0,1,28'h400,1,1,28'h300,128'h55,0,RD2, 0,1,28'h300,1,128'h55,0,0));
        vecs.push_back(v(0,1,28'h400,1,0,28'h300,128'h55,1,RD2, 0,1,28'h300,1,128'h55,0,1));
        vecs.push_back(v(0,1,28'h400,1,0,28'h300,0,      0,RD2, 0,0,0,      0,0,      0,0));
        // I drops its request mid-grant; command holds until mem_ready.
        vecs.push_back(v(0,0,0,      1,0,28'h300,0,      0,RD2, 1,0,28'h400,1,0,      0,0));
        vecs.push_back(v(0,0,0,      1,0,28'h300,0,      0,RD2, 1,0,28'h400,0,0,      0,0));
        vecs.push_back(v(0,0,0,      1,0,28'h300,0,      1,BEEF,1,0,28'h400,0,0,      1,0));
        vecs.push_back(v(0,0,0,      1,0,28'h300,0,      0,RD2, 0,0,0,      0,0,      0,0));
        vecs.push_back(v(0,0,0,      1,0,28'h300,0,      1,RD2, 1,0,28'h300,0,0,      0,1));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            @(negedge clk);
            ic_read = vecs[i].icr; ic_addr = vecs[i].ica;
            dc_read = vecs[i].dcr; dc_write = vecs[i].dcw;
            dc_addr = vecs[i].dca; dc_wdata = vecs[i].dcwd;
            mem_ready = vecs[i].mrdy; mem_rdata = vecs[i].mrd;
            #2;
            tag = $sformatf("v%0d", i);
            chk({tag, "_mem_read"}, mem_read, vecs[i].e_mr);
            chk({tag, "_mem_write"}, mem_write, vecs[i].e_mw);
            chk({tag, "_ic_ready"}, ic_ready, vecs[i].e_ir);
            chk({tag, "_dc_ready"}, dc_ready, vecs[i].e_dr);
            if (vecs[i].e_mr || vecs[i].e_mw) chk({tag, "_mem_addr"}, mem_addr, vecs[i].e_ma);
            if (vecs[i].chk_wd) chk({tag, "_mem_wdata"}, mem_wdata, vecs[i].e_mwd);
            chk({tag, "_ic_rdata"}, ic_rdata, vecs[i].mrd);
            chk({tag, "_dc_rdata"}, dc_rdata, vecs[i].mrd);
        end

        // Continuous contention: grants must alternate D,I,D,I,D,I.
        do_reset();
        @(negedge clk);
        ic_read = 1; ic_addr = 28'h111; dc_read = 1; dc_addr = 28'h222;
        for (int t = 0; t < 6; t++) begin
            got[t] = 9;
            n = 0;
            while (got[t] == 9 && n < 20) begin
                @(negedge clk);
                mem_ready = mem_read | mem_write;
                #2;
                if (ic_ready && dc_ready) chk("rr_both_ready", 1, 0);
                if (dc_ready) got[t] = 1;
                else if (ic_ready) got[t] = 0;
                n++;
            end
            chk($sformatf("rr_order_%0d", t), got[t], (t % 2 == 0) ? 1 : 0);
        end
        clear_inputs();

        // Write-back command and address stability against dc_addr changes.
        do_reset();
        @(negedge clk);
        dc_write = 1; dc_addr = 28'h0ABCDEF; dc_wdata = 128'h1234;
        @(negedge clk);
        #2;
        chk("wb_mem_write", mem_write, 1);
        chk("wb_mem_read", mem_read, 0);
        chk("wb_mem_wdata", mem_wdata, 128'h1234);
        chk("wb_mem_addr", mem_addr, 28'h0ABCDEF);
        dc_addr = 28'h1111111;
        @(negedge clk);
        #2;
        chk("wb_addr_hold", mem_addr, 28'h0ABCDEF);
        mem_ready = 1;
        #1;
        chk("wb_dc_ready", dc_ready, 1);
        clear_inputs();

        // Reset in the middle of an I grant abandons the transaction.
        do_reset();
        @(negedge clk);
        ic_read = 1; ic_addr = 28'h77;
        @(negedge clk);
        #2;
        chk("mid_rst_pre_read", mem_read, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_async_drop", mem_read, 0);
        @(negedge clk);
        ic_read = 0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_ready = 1;
            #2;
            chk($sformatf("post_rst_ic_ready_%0d", k), ic_ready, 0);
            chk($sformatf("post_rst_dc_ready_%0d", k), dc_ready, 0);
            chk($sformatf("post_rst_mem_read_%0d", k), mem_read, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
